// File: rtl/ps2_key_decoder_if.sv
// Scancode-in / key-event-out bundle of ps2_key_decoder.
// The master drives the scancode stream and the slave (the decoder) drives the events.
interface ps2_key_decoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             event_valid;
    logic [7:0]       event_code;
    logic             event_ext;
    logic             event_release;
    logic             event_repeat;
    logic [7:0]       event_ascii;
    logic             key_held;
    logic [7:0]       held_code;
    logic             held_ext;
    logic [CNT_W-1:0] press_count;
    logic             proto_err;

    modport master (
        output in_valid, in_data,
        input  event_valid, event_code, event_ext, event_release, event_repeat,
               event_ascii, key_held, held_code, held_ext, press_count, proto_err
    );

    modport slave (
        input  in_valid, in_data,
        output event_valid, event_code, event_ext, event_release, event_repeat,
               event_ascii, key_held, held_code, held_ext, press_count, proto_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Turns a PS/2 set-2 scancode byte stream into registered key events.
// It also tracks the held key and counts distinct presses.
module ps2_key_decoder #(
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    ps2_key_decoder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    state_t           state_q, state_d;
    logic             fire_ev, fire_err, ev_ext, ev_rel, match;

    logic             event_valid_q, event_ext_q, event_release_q, event_repeat_q;
    logic [7:0]       event_code_q, event_ascii_q;
    logic             key_held_q, held_ext_q, proto_err_q;
    logic [7:0]       held_code_q;
    logic [CNT_W-1:0] press_count_q;

    function automatic logic [7:0] ascii_of(input logic [7:0] sc);
        logic [7:0] a;
        case (sc)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fire_ev  = 1'b0;
        fire_err = 1'b0;
        ev_ext   = 1'b0;
        ev_rel   = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_data == 8'hE0)      state_d = S_E0;
                    else if (bus.in_data == 8'hF0) state_d = S_F0;
                    else                           fire_ev = 1'b1;
                end
                S_E0: begin
                    if (bus.in_data == 8'hF0)      state_d = S_E0F0;
                    else if (bus.in_data != 8'hE0) begin
                        fire_ev = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_F0, S_E0F0: begin
                    state_d = S_IDLE;
                    if (bus.in_data == 8'hE0 || bus.in_data == 8'hF0) begin
                        fire_err = 1'b1;
                    end else begin
                        fire_ev = 1'b1;
                        ev_rel  = 1'b1;
                        ev_ext  = (state_q == S_E0F0);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign match = key_held_q && (held_ext_q == ev_ext) && (held_code_q == bus.in_data);

    // Held-key state is updated alongside the event so both are visible in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            event_valid_q   <= 1'b0;
            event_code_q    <= '0;
            event_ext_q     <= 1'b0;
            event_release_q <= 1'b0;
            event_repeat_q  <= 1'b0;
            event_ascii_q   <= '0;
            key_held_q      <= 1'b0;
            held_code_q     <= '0;
            held_ext_q      <= 1'b0;
            press_count_q   <= '0;
            proto_err_q     <= 1'b0;
        end else begin
            event_valid_q <= fire_ev;
            proto_err_q   <= fire_err;
            if (fire_ev) begin
                event_code_q    <= bus.in_data;
                event_ext_q     <= ev_ext;
                event_release_q <= ev_rel;
                event_repeat_q  <= !ev_rel && match;
                event_ascii_q   <= ev_ext ? 8'h00 : ascii_of(bus.in_data);
                if (!ev_rel) begin
                    if (!match) begin
                        key_held_q    <= 1'b1;
                        held_code_q   <= bus.in_data;
                        held_ext_q    <= ev_ext;
                        press_count_q <= press_count_q + CNT_W'(1);
                    end
                end else if (match) begin
                    key_held_q <= 1'b0;
                end
            end
        end
    end

    assign bus.event_valid   = event_valid_q;
    assign bus.event_code    = event_code_q;
    assign bus.event_ext     = event_ext_q;
    assign bus.event_release = event_release_q;
    assign bus.event_repeat  = event_repeat_q;
    assign bus.event_ascii   = event_ascii_q;
    assign bus.key_held      = key_held_q;
    assign bus.held_code     = held_code_q;
    assign bus.held_ext      = held_ext_q;
    assign bus.press_count   = press_count_q;
    assign bus.proto_err     = proto_err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scancode sequences push expected events,
// and a negedge monitor pops and compares them, including their exact arrival cycle.
module tb_ps2_key_decoder;
    logic clock = 1'b0;
    logic reset;
    int unsigned pcnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  code;
        logic        ext, rel, rep;
        logic [7:0]  ascii;
        logic        held;
        logic [7:0]  hcode;
        logic        hext;
        logic [7:0]  cnt;
        int unsigned due;
    } exp_t;

    exp_t q[$];

    ps2_key_decoder_if #(.CNT_W(8)) bus ();
    ps2_key_decoder #(.CNT_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) pcnt <= pcnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcnt);
        end
    endtask

    // Expectations are pushed just before the byte that completes the sequence is driven.
    task automatic push_ev(input logic [7:0] code, input logic ext, input logic rel,
                           input logic rep, input logic [7:0] ascii, input logic held,
                           input logic [7:0] hcode, input logic hext, input logic [7:0] cnt);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.ext = ext; e.rel = rel; e.rep = rep;
        e.ascii = ascii; e.held = held; e.hcode = hcode; e.hext = hext; e.cnt = cnt;
        e.due = pcnt + 1;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '{is_err: 1'b1, code: 8'h00, ext: 1'b0, rel: 1'b0, rep: 1'b0, ascii: 8'h00,
              held: 1'b0, hcode: 8'h00, hext: 1'b0, cnt: 8'h00, due: pcnt + 1};
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("rst_event_valid", bus.event_valid, 0);
        check("rst_event_code", bus.event_code, 0);
        check("rst_event_flags", {bus.event_ext, bus.event_release, bus.event_repeat}, 0);
        check("rst_event_ascii", bus.event_ascii, 0);
        check("rst_key_held", bus.key_held, 0);
        check("rst_held", {bus.held_ext, bus.held_code}, 0);
        check("rst_press_count", bus.press_count, 0);
        check("rst_proto_err", bus.proto_err, 0);
        reset = 1'b0;
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (bus.event_valid || bus.proto_err) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {bus.event_valid, bus.proto_err}, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", pcnt, e.due);
                    if (e.is_err) begin
                        check("err_strobes", {bus.event_valid, bus.proto_err}, 2'b01);
                    end else begin
                        check("ev_strobes", {bus.event_valid, bus.proto_err}, 2'b10);
                        check("event_code", bus.event_code, e.code);
                        check("event_ext", bus.event_ext, e.ext);
                        check("event_release", bus.event_release, e.rel);
                        check("event_repeat", bus.event_repeat, e.rep);
                        check("event_ascii", bus.event_ascii, e.ascii);
                        check("key_held", bus.key_held, e.held);
                        check("held_code", bus.held_code, e.hcode);
                        check("held_ext", bus.held_ext, e.hext);
                        check("press_count", bus.press_count, e.cnt);
                    end
                end
            end else if (q.size() != 0 && q[0].due <= pcnt) begin
                e = q.pop_front();
                check("missing_output", {bus.event_valid, bus.proto_err}, e.is_err ? 2'b01 : 2'b10);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clock);
        do_reset();

        // T1: make then break of 'a'
        push_ev(8'h1C, 0, 0, 0, 8'h61, 1, 8'h1C, 0, 8'd1); send(8'h1C);
        send(8'hF0);
        push_ev(8'h1C, 0, 1, 0, 8'h61, 0, 8'h1C, 0, 8'd1); send(8'h1C);
        repeat (2) @(negedge clock);

        // T2: typematic repeats
        do_reset();
        push_ev(8'h1C, 0, 0, 0, 8'h61, 1, 8'h1C, 0, 8'd1); send(8'h1C);
        push_ev(8'h1C, 0, 0, 1, 8'h61, 1, 8'h1C, 0, 8'd1); send(8'h1C);
        push_ev(8'h1C, 0, 0, 1, 8'h61, 1, 8'h1C, 0, 8'd1); send(8'h1C);
        send(8'hF0);
        push_ev(8'h1C, 0, 1, 0, 8'h61, 0, 8'h1C, 0, 8'd1); send(8'h1C);
        repeat (2) @(negedge clock);

        // T3: extended key
        do_reset();
        send(8'hE0);
        push_ev(8'h74, 1, 0, 0, 8'h00, 1, 8'h74, 1, 8'd1); send(8'h74);
        send(8'hE0); send(8'hF0);
        push_ev(8'h74, 1, 1, 0, 8'h00, 0, 8'h74, 1, 8'd1); send(8'h74);
        repeat (2) @(negedge clock);

        // T4: last-pressed wins, stale break, counter wrap
        do_reset();
        push_ev(8'h1C, 0, 0, 0, 8'h61, 1, 8'h1C, 0, 8'd1); send(8'h1C);
        push_ev(8'h32, 0, 0, 0, 8'h62, 1, 8'h32, 0, 8'd2); send(8'h32);
        send(8'hF0);
        push_ev(8'h1C, 0, 1, 0, 8'h61, 1, 8'h32, 0, 8'd2); send(8'h1C);
        for (int i = 3; i <= 256; i++) begin
            logic [7:0] k;
            k = (i % 2 == 1) ? 8'h1C : 8'h32;
            push_ev(k, 0, 0, 0, (k == 8'h1C) ? 8'h61 : 8'h62, 1, k, 0, 8'(i));
            send(k);
        end
        push_ev(8'h32, 0, 0, 1, 8'h62, 1, 8'h32, 0, 8'h00); send(8'h32);
        repeat (2) @(negedge clock);

        // T5: illegal prefix, then reset discarding a pending E0
        do_reset();
        send(8'hF0);
        push_err(); send(8'hE0);
        push_ev(8'h1C, 0, 0, 0, 8'h61, 1, 8'h1C, 0, 8'd1); send(8'h1C);
        send(8'hE0);
        do_reset();
        push_ev(8'h74, 0, 0, 0, 8'h00, 1, 8'h74, 0, 8'd1); send(8'h74);
        repeat (2) @(negedge clock);

        // T6: back-to-back bytes
        do_reset();
        push_ev(8'h1C, 0, 0, 0, 8'h61, 1, 8'h1C, 0, 8'd1); send(8'h1C);
        send(8'hF0);
        push_ev(8'h1C, 0, 1, 0, 8'h61, 0, 8'h1C, 0, 8'd1); send(8'h1C);
        push_ev(8'h16, 0, 0, 0, 8'h31, 1, 8'h16, 0, 8'd2); send(8'h16);

        repeat (5) @(negedge clock);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
